// File: rtl/fpnew_pkg.sv
// Shared FP types for the cast unit.
// Supplies status_t, the IEEE 754 exception flag set
// (invalid, divide-by-zero, overflow, underflow, inexact).
package fpnew_pkg;

    typedef struct packed {
        logic nv;  // invalid operation
        logic dz;  // divide by zero
        logic of;  // overflow
        logic uf;  // underflow
        logic nx;  // inexact
    } status_t;

endpackage

// File: rtl/fpnew_cast_result_buffer.sv
// Elastic output buffer at the consumer end of the cast pipeline.
// Stores {result, status, extension bit, tag, aux} in a small circular FIFO
// and presents the entries in order downstream. Upstream ready depends only
// on the fill state, so the ready chain back through the pipeline is cut here.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   result_i .. aux_i          incoming entry fields
//   in_valid_i / in_ready_o    upstream handshake
//   flush_i                    synchronous flush (drops everything held and the input)
//   result_o .. aux_o          head entry fields
//   out_valid_o / out_ready_i  downstream handshake
//   usage_o                    number of entries held
//   busy_o                     entries held or input pending
module fpnew_cast_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width       = 64,
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0,
    parameter type         TagType     = logic,
    parameter type         AuxType     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           result_i,
    input  status_t                    status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    input  AuxType                     aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output AuxType                     aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth+1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth-1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             extension_bit;
        TagType           tag;
        AuxType           aux;
    } entry_t;

    entry_t             mem_reg [Depth];
    logic [PtrW-1:0]    write_ptr_reg, write_ptr_next;
    logic [PtrW-1:0]    read_ptr_reg,  read_ptr_next;
    logic [CntW-1:0]    count_reg,     count_next;

    entry_t in_entry;
    entry_t head_entry;
    logic   empty;
    logic   bypass_active;  // fall-through path selected this cycle
    logic   push, pop;
    logic   bypass_pop;     // entry consumed straight from the input, never stored
    logic   store;          // entry actually written into storage
    logic   drop;           // stored head entry removed

    assign in_entry = '{result:        result_i,
                        status:        status_i,
                        extension_bit: extension_bit_i,
                        tag:           tag_i,
                        aux:           aux_i};

    assign empty         = (count_reg == '0);
    assign bypass_active = FallThrough && empty;

    // Ready is a function of fill state only; a pop in the same cycle does not
    // free a slot for a push into a full buffer.
    assign in_ready_o  = (count_reg != DepthCnt) | flush_i;
    assign out_valid_o = bypass_active ? (in_valid_i & ~flush_i) : (~empty & ~flush_i);

    assign head_entry = bypass_active ? in_entry : mem_reg[read_ptr_reg];

    assign push       = in_valid_i & in_ready_o;
    assign pop        = out_valid_o & out_ready_i;
    assign bypass_pop = bypass_active & pop;
    // A flushed input is accepted but discarded, so it is never written.
    assign store      = push & ~bypass_pop & ~flush_i;
    assign drop       = pop & ~bypass_pop;

    always_comb begin
        write_ptr_next = write_ptr_reg;
        read_ptr_next  = read_ptr_reg;
        count_next     = count_reg;
        if (flush_i) begin
            write_ptr_next = '0;
            read_ptr_next  = '0;
            count_next     = '0;
        end else begin
            // Explicit wrap compare so non-power-of-two depths work.
            if (store) begin
                write_ptr_next = (write_ptr_reg == LastPtr) ? '0 : write_ptr_reg + 1'b1;
            end
            if (drop) begin
                read_ptr_next = (read_ptr_reg == LastPtr) ? '0 : read_ptr_reg + 1'b1;
            end
            if (store && !drop) begin
                count_next = count_reg + 1'b1;
            end else if (drop && !store) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_ptr_reg <= '0;
            read_ptr_reg  <= '0;
            count_reg     <= '0;
        end else begin
            write_ptr_reg <= write_ptr_next;
            read_ptr_reg  <= read_ptr_next;
            count_reg     <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Depth; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mem_reg[gi] <= '0;
                end else if (store && (write_ptr_reg == PtrW'(gi))) begin
                    mem_reg[gi] <= in_entry;
                end
            end
        end
    endgenerate

    assign result_o        = head_entry.result;
    assign status_o        = head_entry.status;
    assign extension_bit_o = head_entry.extension_bit;
    assign tag_o           = head_entry.tag;
    assign aux_o           = head_entry.aux;

    assign usage_o = count_reg;
    assign busy_o  = ~empty | in_valid_i;

endmodule

// File: doc/fpnew_cast_result_buffer.md
Name: fpnew_cast_result_buffer

Overview:
Elastic output buffer that terminates the cast-unit pipeline on its consumer side. It accepts result, status, tag and aux from the last cast pipeline stage over a valid/ready handshake and stores them in a small circular FIFO. It presents the stored entries in order to the downstream arbiter/writeback. Its upstream ready depends only on its own fill state, which cuts the combinational ready chain running back through the pipeline stages.

Parameters:
Width, 64, result width in bits
Depth, 2, number of entries; must be >= 1; non-power-of-two allowed
FallThrough, 0, 1 = data may pass combinationally from input to output when the buffer is empty
TagType, logic, operation tag type
AuxType, logic, auxiliary data type

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
result_i  in  Width  cast result
status_i  in  fpnew_pkg::status_t  IEEE exception flags
extension_bit_i  in  1  NaN-box/sign-extension bit
tag_i  in  TagType  tag
aux_i  in  AuxType  aux data
in_valid_i  in  1  upstream valid
in_ready_o  out  1  buffer can accept
flush_i  in  1  synchronous flush
result_o  out  Width  head result
status_o  out  fpnew_pkg::status_t  head status
extension_bit_o  out  1  head extension bit
tag_o  out  TagType  head tag
aux_o  out  AuxType  head aux
out_valid_o  out  1  head valid
out_ready_i  in  1  downstream ready
usage_o  out  $clog2(Depth+1)  current entry count
busy_o  out  1  entries held or input valid

Behaviour:
- One clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: write_ptr, read_ptr and count are 0; all storage is '0.
  - Outputs after reset: out_valid_o=0, in_ready_o=1, usage_o=0, busy_o=0, data outputs 0.
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i.
- in_ready_o = (count != Depth) | flush_i. It never depends on out_ready_i, so a full buffer refuses a push even when a pop happens in the same cycle.
- Push stores the entry at write_ptr. write_ptr increments and wraps Depth-1 -> 0 by explicit compare, not by modulo-2^n.
- Pop advances read_ptr with the same wrap rule.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Output data is always the storage entry at read_ptr (registered).
  - out_valid_o = (count != 0) & ~flush_i.
  - Latency is 1 cycle from push to out_valid_o.
- FallThrough=1 and count==0:
  - out_valid_o = in_valid_i and the outputs mux in the input fields (latency 0).
  - If pop occurs in that cycle, the entry is not written and the pointers and count are unchanged.
  - If there is no pop, the entry is stored normally.
- flush_i, synchronous:
  - In the same cycle: out_valid_o forced to 0 and in_ready_o forced to 1; the input is accepted and discarded.
  - Next cycle: pointers and count are 0. Storage contents are not cleared.
- busy_o = (count != 0) | in_valid_i.
- usage_o = count.
- Reset mid-operation: all entries are lost immediately (async). No output glitches beyond the async clear.
- Upstream must hold its data stable while in_valid_i & ~in_ready_o. The buffer holds its head stable while out_valid_o & ~out_ready_i.

Decomposition:
- fpnew_pkg already supplies status_t. Add no new typedefs.
- Internally, pack {result, status, extension_bit, tag, aux} into one local struct so storage is a single array.
- No sub-module is needed. Pointer wrap logic stays inline.

Test Plan:
1. Depth=2, FallThrough=0. Push result 64'h3FF0_0000_0000_0000, tag 1, with out_ready_i=1 -> out_valid_o rises 1 cycle later with the same result and tag; usage_o goes 1 then 0.
2. Depth=2, out_ready_i=0. Push tags 1,2,3 back-to-back -> in_ready_o=0 after the 2nd push and tag 3 is held upstream. Raise out_ready_i -> tags come out in order 1,2,3.
3. Full buffer with in_valid_i=1 and out_ready_i=1 in the same cycle -> only the pop occurs and usage_o goes from 2 to 1. Next cycle the push is accepted.
4. Depth=3, random ready/valid, 20 pushes -> all tags 0..19 emerge in order through the pointer wrap, with no loss or duplication.
5. Two entries held, pulse flush_i while in_valid_i=1 -> out_valid_o=0 in that cycle; next cycle usage_o=0 and busy_o=in_valid_i. The discarded tag never appears.
6. FallThrough=1, empty buffer. in_valid_i=1 and out_ready_i=1 with result 64'h1 -> out_valid_o=1 in the same cycle with result 64'h1, usage_o stays 0. Then assert rst_ni=0 mid-fill -> out_valid_o=0 immediately.
